// File: rtl/llc_bus_if.sv
// llc_bus_if: request/response handshake and system-bus signals of the LLC bus interface
interface llc_bus_if #(
    parameter int ADDR_BITS  = 32,
    parameter int N_SNOOPERS = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_op;
    logic [ADDR_BITS-1:0]    req_addr;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_snoop;
    logic                    rsp_err;
    logic                    bus_cmd_valid;
    logic [2:0]              bus_cmd;
    logic [ADDR_BITS-1:0]    bus_addr;
    logic [2*N_SNOOPERS-1:0] snoop_in;
    logic                    bus_wb_done;
    logic                    bus_beat;
    modport slave (
        input  req_valid, req_op, req_addr, rsp_ready, snoop_in, bus_wb_done, bus_beat,
        output req_ready, rsp_valid, rsp_snoop, rsp_err, bus_cmd_valid, bus_cmd, bus_addr
    );
    modport master (
        output req_valid, req_op, req_addr, rsp_ready, snoop_in, bus_wb_done, bus_beat,
        input  req_ready, rsp_valid, rsp_snoop, rsp_err, bus_cmd_valid, bus_cmd, bus_addr
    );
endinterface

// File: rtl/llc_bus_interface.sv
// llc_bus_interface: runs LLC bus operations through address, snoop, write-back retry and data phases
module llc_bus_interface #(
    parameter int ADDR_BITS        = 32,
    parameter int BYTE_OFFSET_BITS = 6,
    parameter int N_SNOOPERS       = 3,
    parameter int SNOOP_DELAY      = 2,
    parameter int BEATS            = 8,
    parameter int WB_TIMEOUT       = 64,
    parameter int MAX_RETRY        = 2
) (
    input logic      clk,
    input logic      rst_n,
    llc_bus_if.slave bus
);
    localparam int CW = $clog2(WB_TIMEOUT + BEATS + SNOOP_DELAY + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    typedef enum logic [2:0] {IDLE, ADDR, SNOOP, WAIT_WB, DATA, RESP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [1:0]            last_q, last_d, comb;
    logic                  sticky_q, sticky_d, err_q, err_d, live_q, live_d;
    logic                  any_m, any_h, inc;
    always_comb begin
        any_m = 1'b0;
        any_h = 1'b0;
        for (int i = 0; i < N_SNOOPERS; i++) begin
            any_m = any_m | (bus.snoop_in[2*i +: 2] == 2'd2);
            any_h = any_h | (bus.snoop_in[2*i +: 2] == 2'd1);
        end
        comb = any_m ? 2'd2 : any_h ? 2'd1 : 2'd0;
    end
    // cmd_q doubles as the registered op: it is only loaded for legal operations
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        last_d   = last_q;
        sticky_d = sticky_q;
        err_d    = err_q;
        live_d   = 1'b1;
        case (state_q)
            IDLE: if (bus.req_valid && live_q) begin
                retry_d  = '0;
                last_d   = 2'd0;
                sticky_d = 1'b0;
                err_d    = 1'b0;
                if (bus.req_op != 3'd0 && bus.req_op <= 3'd4) begin
                    cmd_d   = bus.req_op;
                    addr_d  = {bus.req_addr[ADDR_BITS-1:BYTE_OFFSET_BITS], {BYTE_OFFSET_BITS{1'b0}}};
                    state_d = ADDR;
                end else begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            ADDR: state_d = SNOOP;
            SNOOP: if (cnt_q == CW'(SNOOP_DELAY - 1)) begin
                last_d   = comb;
                sticky_d = sticky_q | any_m;
                if (any_m && (cmd_q == 3'd1 || cmd_q == 3'd4)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = WAIT_WB;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end else
                    state_d = (cmd_q == 3'd3) ? RESP : DATA;
            end
            WAIT_WB: if (bus.bus_wb_done)
                state_d = ADDR;
            else if (cnt_q == CW'(WB_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = RESP;
            end
            DATA: if (bus.bus_beat && cnt_q == CW'(BEATS - 1)) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inc   = (state_q == SNOOP) || (state_q == WAIT_WB) || (state_q == DATA && bus.bus_beat);
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(inc);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            last_q   <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
            live_q   <= live_d;
        end
    end
    assign bus.req_ready     = (state_q == IDLE) && live_q;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_snoop     = sticky_q ? 2'd2 : last_q;
    assign bus.rsp_err       = err_q;
    assign bus.bus_cmd_valid = (state_q == ADDR);
    assign bus.bus_cmd       = cmd_q;
    assign bus.bus_addr      = addr_q;
endmodule

// File: tb/tb_llc_bus_interface.sv
// tb_llc_bus_interface: directed checks of the LLC bus interface with hand-computed expectations
module tb_llc_bus_interface;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int passed = 0;
    int total = 0;
    int ncmd = 0;
    int nrsp = 0;
    int base, rbase, lat;
    llc_bus_if #(.ADDR_BITS(32), .N_SNOOPERS(3)) bif ();
    llc_bus_interface dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bif.bus_cmd_valid) ncmd <= ncmd + 1;
        if (bif.rsp_valid) nrsp <= nrsp + 1;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a);
        int k = 0;
        while (!bif.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("issue_ready", bif.req_ready, 1);
        bif.req_valid = 1'b1;
        bif.req_op    = op;
        bif.req_addr  = a;
        @(negedge clk);
        bif.req_valid = 1'b0;
    endtask
    task automatic wait_rsp(input int max, output int n);
        n = 1;
        while (!bif.rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", bif.rsp_valid, 1);
    endtask
    task automatic run_beats();
        for (int i = 0; i < 8; i++) begin
            chk("no_early_rsp", bif.rsp_valid, 0);
            bif.bus_beat = 1'b1;
            @(negedge clk);
        end
        bif.bus_beat = 1'b0;
    endtask
    task automatic handshake();
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        chk("rsp_dropped", bif.rsp_valid, 0);
        chk("back_idle", bif.req_ready, 1);
    endtask
    initial begin
        bif.req_valid = 0; bif.req_op = 0; bif.req_addr = 0; bif.rsp_ready = 0;
        bif.snoop_in = 0; bif.bus_wb_done = 0; bif.bus_beat = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", bif.req_ready, 0);
        chk("rst_outs", {bif.rsp_valid, bif.rsp_snoop, bif.rsp_err, bif.bus_cmd_valid, bif.bus_cmd}, 0);
        chk("rst_addr", bif.bus_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_low_after_release", bif.req_ready, 0);
        @(negedge clk);
        chk("ready_rises", bif.req_ready, 1);
        // READ, all NOHIT
        base = ncmd;
        issue(3'd1, 32'h0000_1234);
        chk("rd_cmd_valid", bif.bus_cmd_valid, 1);
        chk("rd_cmd", bif.bus_cmd, 1);
        chk("rd_addr", bif.bus_addr, 32'h0000_1200);
        @(negedge clk);
        chk("rd_cmd_pulse", bif.bus_cmd_valid, 0);
        repeat (2) @(negedge clk);
        run_beats();
        chk("rd_rsp_valid", bif.rsp_valid, 1);
        chk("rd_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b000);
        chk("rd_addr_hold", bif.bus_addr, 32'h0000_1200);
        handshake();
        chk("rd_pulses", ncmd - base, 1);
        // INVALIDATE, snooper1 HIT
        bif.snoop_in = 6'b000100;
        issue(3'd3, 32'hABCD_0040);
        chk("inv_cmd", bif.bus_cmd, 3);
        chk("inv_addr", bif.bus_addr, 32'hABCD_0040);
        wait_rsp(20, lat);
        chk("inv_latency", lat, 4);
        chk("inv_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b010);
        handshake();
        // RWIM, snooper2 HITM, write-back after 5 cycles, reissue NOHIT
        base = ncmd;
        bif.snoop_in = 6'b100000;
        issue(3'd4, 32'h0000_0100);
        repeat (3) @(negedge clk);
        bif.snoop_in = 6'b000000;
        repeat (5) @(negedge clk);
        bif.bus_wb_done = 1'b1;
        @(negedge clk);
        bif.bus_wb_done = 1'b0;
        chk("rwim_reissue", bif.bus_cmd_valid, 1);
        chk("rwim_cmd", bif.bus_cmd, 4);
        repeat (3) @(negedge clk);
        run_beats();
        chk("rwim_rsp_valid", bif.rsp_valid, 1);
        chk("rwim_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b100);
        chk("rwim_pulses", ncmd - base, 2);
        handshake();
        // WRITE with HITM: no retry, data phase still runs
        base = ncmd;
        bif.snoop_in = 6'b000010;
        issue(3'd2, 32'h0000_003F);
        chk("wr_addr", bif.bus_addr, 0);
        chk("wr_cmd", bif.bus_cmd, 2);
        repeat (3) @(negedge clk);
        run_beats();
        chk("wr_rsp_valid", bif.rsp_valid, 1);
        chk("wr_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b100);
        chk("wr_pulses", ncmd - base, 1);
        handshake();
        // READ with HITM on every phase: retry limit
        base = ncmd;
        issue(3'd1, 32'h0000_0800);
        repeat (2) begin
            repeat (3) @(negedge clk);
            bif.bus_wb_done = 1'b1;
            @(negedge clk);
            bif.bus_wb_done = 1'b0;
        end
        wait_rsp(20, lat);
        chk("retry_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b101);
        chk("retry_pulses", ncmd - base, 3);
        handshake();
        // HITM then no write-back: timeout after 64 cycles
        issue(3'd1, 32'h0000_0900);
        wait_rsp(200, lat);
        chk("wb_timeout_latency", lat, 68);
        chk("wb_timeout_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b101);
        handshake();
        // illegal op
        base = ncmd;
        bif.snoop_in = 6'b000000;
        issue(3'd7, 32'h0000_1000);
        chk("ill_rsp_valid", bif.rsp_valid, 1);
        chk("ill_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b001);
        chk("ill_cmd_hold", bif.bus_cmd, 1);
        handshake();
        chk("ill_no_cmd", ncmd - base, 0);
        // reset during DATA after 3 beats
        issue(3'd1, 32'h0000_0040);
        repeat (3) @(negedge clk);
        repeat (3) begin
            bif.bus_beat = 1'b1;
            @(negedge clk);
        end
        bif.bus_beat = 1'b0;
        rbase = nrsp;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {bif.req_ready, bif.rsp_valid, bif.rsp_snoop, bif.rsp_err, bif.bus_cmd_valid, bif.bus_cmd}, 0);
        chk("mid_rst_addr", bif.bus_addr, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold", {bif.req_ready, bif.rsp_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", bif.req_ready, 1);
        chk("mid_rst_no_rsp", nrsp - rbase, 0);
        issue(3'd1, 32'h0000_2000);
        chk("post_rst_addr", bif.bus_addr, 32'h0000_2000);
        repeat (3) @(negedge clk);
        run_beats();
        chk("post_rst_rsp_valid", bif.rsp_valid, 1);
        chk("post_rst_rsp", {bif.rsp_snoop, bif.rsp_err}, 3'b000);
        handshake();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/llc_bus_interface.md
Name: llc_bus_interface

Overview:
- Sits directly downstream of the last-level cache and carries out its bus operations (READ, WRITE, INVALIDATE, RWIM) on the shared system bus.
- Runs the address phase, then the snoop window, where it collects and combines the responses of the other caches.
- Handles HITM write-back retries and the data-beat phase.
- Returns the combined snoop result to the cache controller with a valid/ready handshake.

Parameters:
ADDR_BITS, 32, physical address width
BYTE_OFFSET_BITS, 6, log2 of line size; bus addresses are line-aligned
N_SNOOPERS, 3, number of other caches driving snoop responses
SNOOP_DELAY, 2, cycles from address phase to snoop sample (>=1)
BEATS, 8, data beats per line transfer
WB_TIMEOUT, 64, max cycles waiting for a snooper write-back
MAX_RETRY, 2, max address-phase reissues after HITM

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  1  cache presents a bus operation
req_ready  out  1  block can accept an operation
req_op  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; other codes are illegal
req_addr  in  ADDR_BITS  operation address
rsp_valid  out  1  operation complete
rsp_ready  in  1  cache accepts the response
rsp_snoop  out  2  0=NOHIT, 1=HIT, 2=HITM
rsp_err  out  1  operation aborted (timeout, retry limit, or illegal op)
bus_cmd_valid  out  1  address-phase strobe
bus_cmd  out  3  operation code on the bus
bus_addr  out  ADDR_BITS  line-aligned address
snoop_in  in  2*N_SNOOPERS  per-snooper response, same encoding as rsp_snoop; code 3 is treated as NOHIT
bus_wb_done  in  1  snooper finished its HITM write-back
bus_beat  in  1  one data beat transferred

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE immediately; all counters and the sticky flag clear.
  - All outputs are 0, including req_ready.
  - req_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-operation abandons the operation silently; no response is issued.
- Handshake:
  - req_ready is 1 only in IDLE.
  - An operation is accepted on a clk edge with req_valid & req_ready. req_op and req_addr are registered at that edge.
- States: IDLE, ADDR, SNOOP, WAIT_WB, DATA, RESP.
- IDLE:
  - On acceptance with a legal op, go to ADDR.
  - On acceptance with an illegal op, go to RESP with rsp_err=1 and rsp_snoop=0.
- ADDR (1 cycle):
  - bus_cmd_valid=1.
  - bus_cmd = the registered op.
  - bus_addr = the registered address with bits [BYTE_OFFSET_BITS-1:0] forced to 0.
  - Go to SNOOP.
  - bus_cmd and bus_addr hold their values until the next address phase; they are 0 after reset.
- SNOOP:
  - Lasts exactly SNOOP_DELAY cycles, with snoop_in sampled on the last cycle.
  - Combining rule: any snooper reporting HITM gives HITM; else any HIT gives HIT; else NOHIT.
  - A sticky flag records whether any phase saw HITM.
- After the snoop sample:
  - HITM on READ or RWIM with retries < MAX_RETRY: increment retries, go to WAIT_WB.
  - HITM on READ or RWIM with retries == MAX_RETRY: go to RESP with rsp_err=1.
  - HITM on WRITE or INVALIDATE: no retry.
  - INVALIDATE goes to RESP.
  - READ, WRITE and RWIM go to DATA.
- WAIT_WB:
  - A cycle counter starts at 0.
  - bus_wb_done=1 goes to ADDR (reissue).
  - If the counter reaches WB_TIMEOUT without bus_wb_done, go to RESP with rsp_err=1.
  - bus_wb_done is ignored in every other state.
- DATA:
  - Count bus_beat pulses.
  - On the BEATS-th pulse, go to RESP the next cycle.
  - There is no DATA timeout.
- RESP:
  - rsp_valid=1; rsp_snoop and rsp_err are stable while rsp_valid is high.
  - rsp_snoop = HITM if the sticky flag is set, else the last combined result.
  - Hold until rsp_ready=1, then go to IDLE.
  - The next req_valid can be accepted in the cycle after the response handshake.
- Latency: minimum acceptance-to-rsp_valid = 2 + SNOOP_DELAY cycles (INVALIDATE, no HITM).

Test Plan:
- READ 0x0000_1234, all snoopers NOHIT, 8 beats: bus_addr=0x0000_1200, bus_cmd=1 pulses one cycle; rsp_snoop=0, rsp_err=0 after the 8th beat.
- INVALIDATE 0xABCD_0040, snooper1 HIT: rsp_valid exactly 4 cycles after acceptance, rsp_snoop=1, no DATA phase entered.
- RWIM 0x100, snooper2 HITM, bus_wb_done after 5 cycles, reissue NOHIT, 8 beats: two address phases, final rsp_snoop=2, rsp_err=0.
- READ with HITM on three consecutive address phases (MAX_RETRY=2): rsp_err=1, rsp_snoop=2, exactly 3 bus_cmd_valid pulses.
- HITM then no bus_wb_done for 64 cycles: rsp_err=1, state returns to IDLE after rsp_ready.
- rst_n low during DATA after 3 beats: outputs 0 immediately, no rsp_valid; a new READ accepted after deassertion completes normally; illegal op 7 gives rsp_err=1 with no bus_cmd_valid.
